// File: rtl/adc_seg7_display.sv
// ADC word to 4-digit multiplexed 7-segment display: sequential double-dabble binary-to-BCD plus digit scan.
// Optional leading-zero blanking is compiled in when the SEG7_LZB_EN macro is defined.
module adc_seg7_display #(
    parameter int CLK_HZ       = 48000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int COMMON_ANODE = 1
) (
    input  logic        CLK_48,
    input  logic        rst_n,
    input  logic [15:0] adc_in,
    output logic [15:0] bcd_out,
    output logic        busy,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int DIV = CLK_HZ / (REFRESH_HZ * 4);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [6:0] SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = (COMMON_ANODE != 0) ? 4'hF : 4'h0;
    localparam logic       DP_OFF  = (COMMON_ANODE != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [11:0]     shadow_q, shadow_d;
    logic [27:0]     sr_q, sr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     bcd_q, bcd_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            dp_q;

    logic [3:0]      nibble;
    logic            blank;
    logic [6:0]      seg_hi;
    logic [3:0]      an_hi;

    // Bits above the 12-bit conversion range are deliberately dropped.
    logic unused_adc_hi;
    assign unused_adc_hi = ^adc_in[15:12];

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [27:0] dabble_step(input logic [27:0] r);
        logic [27:0] adj;
        adj = r;
        for (int i = 0; i < 4; i++) begin
            if (adj[12 + 4*i +: 4] >= 4'd5)
                adj[12 + 4*i +: 4] = adj[12 + 4*i +: 4] + 4'd3;
        end
        return {adj[26:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // Conversion FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (adc_in[11:0] != shadow_q) begin
                    shadow_d = adc_in[11:0];
                    sr_d     = {16'h0000, adc_in[11:0]};
                    cnt_d    = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = dabble_step(sr_q);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd11) state_d = DONE;
            end
            DONE: begin
                bcd_d   = sr_q[27:12];
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan; seg and an are computed from the same index so they update on the same edge.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(DIV - 1)) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end

        nibble = bcd_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        case (idx_q)
            2'd3:    blank = (bcd_q[15:12] == 4'h0);
            2'd2:    blank = (bcd_q[15:8]  == 8'h00);
            2'd1:    blank = (bcd_q[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        seg_hi = blank ? 7'h00 : decode(nibble);
        an_hi  = 4'b0001 << idx_q;
        seg_d  = (COMMON_ANODE != 0) ? ~seg_hi : seg_hi;
        an_d   = (COMMON_ANODE != 0) ? ~an_hi  : an_hi;
    end

    always_ff @(posedge CLK_48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
            dp_q     <= DP_OFF;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            shadow_q <= shadow_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            dp_q     <= DP_OFF;
        end
    end

    assign bcd_out = bcd_q;
    assign busy    = busy_q;
    assign seg     = seg_q;
    assign an      = an_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_adc_seg7_display.sv
// Self-checking bench for adc_seg7_display: vector table with exact latency, scan sequence,
// reset/abort and update-while-busy sequences, and randomized values against an arithmetic model.
module tb_adc_seg7_display;

    logic        CLK_48 = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] adc_in = 16'h0000;
    logic [15:0] bcd_out;
    logic        busy;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    adc_seg7_display #(
        .CLK_HZ      (4000),
        .REFRESH_HZ  (250),
        .COMMON_ANODE(1)
    ) dut (
        .CLK_48 (CLK_48),
        .rst_n  (rst_n),
        .adc_in (adc_in),
        .bcd_out(bcd_out),
        .busy   (busy),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    always #5 CLK_48 = ~CLK_48;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [15:0] adc;
        logic [15:0] bcd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int shadow_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK_48);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0] th, hu, te, on;
        th = 4'(v / 1000);
        hu = 4'((v / 100) % 10);
        te = 4'((v / 10) % 10);
        on = 4'(v % 10);
        return {th, hu, te, on};
    endfunction

    // Common-anode pattern expected on digit position d for displayed value v.
    function automatic logic [6:0] exp_seg(input int v, input int d);
        int p;
        int dig;
        logic [6:0] pat;
        p = 1;
        for (int j = 0; j < d; j++) p = p * 10;
        dig = (v / p) % 10;
        pat = (LZB && d > 0 && v < p) ? 7'h00 : GLYPH[dig];
        return ~pat;
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            step();
            k++;
        end
        check("busy_clear", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_display(input int v);
        logic [3:0] target;
        int k;
        step();
        for (int d = 0; d < 4; d++) begin
            target = ~(4'b0001 << d);
            k = 0;
            while (an !== target && k < 40) begin
                step();
                k++;
            end
            check("scan_digit", {28'b0, an}, {28'b0, target});
            check("seg_digit", {25'b0, seg}, {25'b0, exp_seg(v, d)});
        end
        check("dp_off", {31'b0, dp}, 32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [3:0] prev_an;
        logic [15:0] prev_bcd;
        logic [31:0] r;
        int k;
        int seen;
        int v;
        int w;

        vecs[0] = '{16'h0FFF, 16'h4095};
        vecs[1] = '{16'hF123, 16'h0291};
        vecs[2] = '{16'h0000, 16'h0000};
        vecs[3] = '{16'h03E8, 16'h1000};
        vecs[4] = '{16'h0007, 16'h0007};
        vecs[5] = '{16'h0999, 16'h2457};

        // Reset state and idle behaviour afterwards.
        step(3);
        check("rst_an",   {28'b0, an},   32'hF);
        check("rst_seg",  {25'b0, seg},  32'h7F);
        check("rst_dp",   {31'b0, dp},   32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_bcd",  {16'b0, bcd_out}, 32'h0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy !== 1'b0) seen++;
        end
        check("no_conv_after_reset", seen, 0);
        check_display(0);

        // Table: exact latency and final value for each vector.
        prev_bcd = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            adc_in = vecs[i].adc;
            v = int'(vecs[i].adc[11:0]);
            step();
            check("busy_rise", {31'b0, busy}, 32'd1);
            step(12);
            check("busy_last", {31'b0, busy}, 32'd1);
            check("bcd_hold", {16'b0, bcd_out}, {16'b0, prev_bcd});
            step();
            check("busy_fall", {31'b0, busy}, 32'd0);
            check("bcd_vec", {16'b0, bcd_out}, {16'b0, vecs[i].bcd});
            check("bcd_model", {16'b0, bcd_out}, {16'b0, to_bcd(v)});
            check_display(v);
            prev_bcd = vecs[i].bcd;
        end

        // Scan order and dwell with 4095 displayed.
        adc_in = 16'h0FFF;
        step();
        wait_idle();
        check("bcd_4095", {16'b0, bcd_out}, 32'h4095);
        step();
        prev_an = an;
        step();
        k = 0;
        while (!(prev_an === 4'b0111 && an === 4'b1110) && k < 80) begin
            prev_an = an;
            step();
            k++;
        end
        check("scan_sync", {28'b0, an}, 32'hE);
        for (int i = 0; i < 32; i++) begin
            check("scan_seq", {28'b0, an}, {28'b0, ~(4'b0001 << ((i / 4) % 4))});
            check("scan_seg", {25'b0, seg}, {25'b0, exp_seg(4095, (i / 4) % 4)});
            if (i == 0)  check("seg_five", {25'b0, seg}, 32'h12);
            if (i == 12) check("seg_four", {25'b0, seg}, 32'h19);
            step();
        end

        // New value arriving during a conversion is picked up afterwards.
        adc_in = 16'd100;
        step(3);
        adc_in = 16'd200;
        step(11);
        check("mid_first_bcd", {16'b0, bcd_out}, 32'h0100);
        check("mid_first_busy", {31'b0, busy}, 32'd0);
        step();
        check("mid_second_busy", {31'b0, busy}, 32'd1);
        step(12);
        check("mid_second_hold", {16'b0, bcd_out}, 32'h0100);
        step();
        check("mid_second_bcd", {16'b0, bcd_out}, 32'h0200);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy !== 1'b0) seen++;
        end
        check("hold_no_conv", seen, 0);

        // Reset mid-SHIFT and mid-scan aborts immediately.
        adc_in = 16'h0ABC;
        step(5);
        check("pre_abort_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_an",   {28'b0, an},   32'hF);
        check("abort_seg",  {25'b0, seg},  32'h7F);
        check("abort_dp",   {31'b0, dp},   32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        adc_in = 16'h0000;
        step(2);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy !== 1'b0) seen++;
        end
        check("abort_no_conv", seen, 0);
        check("abort_bcd", {16'b0, bcd_out}, 32'h0);
        shadow_m = 0;

        // Leading-zero blanking behaviour (depends on build option).
        adc_in = 16'd7;
        step();
        wait_idle();
        check("lzb7_bcd", {16'b0, bcd_out}, 32'h0007);
        check_display(7);
        adc_in = 16'd1000;
        step();
        wait_idle();
        check_display(1000);
        shadow_m = 1000;

        // Randomized values, repeats and updates while busy.
        for (int i = 0; i < 25; i++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    adc_in = {r[15:12], 12'(shadow_m)};
                    seen = 0;
                    for (int j = 0; j < 4; j++) begin
                        step();
                        if (busy !== 1'b0) seen++;
                    end
                    check("rand_repeat_idle", seen, 0);
                end
                1: begin
                    adc_in = r[15:0];
                    v = int'(r[11:0]);
                    w = int'(r[27:16]);
                    step();
                    if (v != shadow_m) check("rand_busy_rise", {31'b0, busy}, 32'd1);
                    step($urandom_range(1, 10));
                    adc_in = {4'h0, r[27:16]};
                    wait_idle();
                    step();
                    wait_idle();
                    check("rand_mid_bcd", {16'b0, bcd_out}, {16'b0, to_bcd(w)});
                    shadow_m = w;
                end
                default: begin
                    adc_in = r[15:0];
                    v = int'(r[11:0]);
                    step();
                    if (v != shadow_m) check("rand_busy_rise", {31'b0, busy}, 32'd1);
                    wait_idle();
                    check("rand_bcd", {16'b0, bcd_out}, {16'b0, to_bcd(v)});
                    if (i % 5 == 0) check_display(v);
                    shadow_m = v;
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
